// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared state encoding, IR field positions and write-back codes for the sequencer
package core_pkg;

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXEC    = 3'd2;
  localparam logic [2:0] S_WAIT_SW = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;
  localparam logic [2:0] S_HALT    = 3'd5;

  typedef enum logic [2:0] {
    ST_FETCH   = S_FETCH,
    ST_DECODE  = S_DECODE,
    ST_EXEC    = S_EXEC,
    ST_WAIT_SW = S_WAIT_SW,
    ST_WB      = S_WB,
    ST_HALT    = S_HALT
  } seq_state_t;

  localparam int IR_J        = 31;
  localparam int IR_B        = 30;
  localparam int IR_WE       = 29;
  localparam int IR_WS_HI    = 28;
  localparam int IR_WS_LO    = 27;
  localparam int IR_ALUOP_HI = 26;
  localparam int IR_ALUOP_LO = 23;
  localparam int IR_RA1_HI   = 22;
  localparam int IR_RA1_LO   = 18;
  localparam int IR_RA2_HI   = 17;
  localparam int IR_RA2_LO   = 13;
  localparam int IR_WA_HI    = 12;
  localparam int IR_WA_LO    = 8;
  localparam int IR_CONST_HI = 7;
  localparam int IR_CONST_LO = 0;

  localparam logic [1:0] WS_SE      = 2'b00;
  localparam logic [1:0] WS_SW      = 2'b01;
  localparam logic [1:0] WS_ALU     = 2'b10;
  localparam logic [1:0] WS_ILLEGAL = 2'b11;

  // Branch offset in bytes: sign-extended word offset times four.
  function automatic logic [31:0] branch_offset(input logic [7:0] const8);
    return {{22{const8[7]}}, const8, 2'b00};
  endfunction

endpackage

// File: rtl/core_pc_unit.sv
// rtl/core_pc_unit.sv - program counter register with sequential/branch next-PC selection
module core_pc_unit
  import core_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        taken,
  input  logic [7:0]  const8,
  output logic [31:0] pc
);

  logic [31:0] r_pc;
  logic [31:0] w_next_pc;

  // Next PC: relative branch target when taken, otherwise fall through; both wrap modulo 2^32.
  always_comb begin
    w_next_pc = r_pc + 32'd4;
    if (taken) begin
      w_next_pc = r_pc + branch_offset(const8);
    end
  end

  // PC register, updated once per retired instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= PC_RESET;
    end else if (load) begin
      r_pc <= w_next_pc;
    end
  end

  assign pc = r_pc;

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle fetch/decode/exec/wb control FSM; SEQ_SINGLE_STEP_EN adds step_i and HALT
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'd0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step_i,
`endif
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  input  logic             cmp_i,
  input  logic             sw_valid,
  output logic             sw_ack,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic [31:0]      pc,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_o
);

  seq_state_t       r_state;
  seq_state_t       w_next_state;
  logic [31:0]      r_instr;
  logic             r_cmp_q;
  logic [CNT_W-1:0] r_retired;

  logic [1:0]       w_ws;
  logic             w_we;
  logic             w_taken;
  logic             w_pc_load;
  logic             w_imem_req;
  logic             w_sw_ack;
  logic             w_rf_we;
  logic [31:0]      w_pc;

  assign w_ws    = r_instr[IR_WS_HI:IR_WS_LO];
  assign w_we    = r_instr[IR_WE];
  assign w_taken = r_instr[IR_J] | (r_instr[IR_B] & r_cmp_q);

  // State register; reset always lands in FETCH, even with single-step enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and per-state control strobes.
  always_comb begin
    w_next_state = r_state;
    w_imem_req   = 1'b0;
    w_sw_ack     = 1'b0;
    w_rf_we      = 1'b0;
    w_pc_load    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_imem_req = 1'b1;
        if (imem_ack) begin
          w_next_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_next_state = ST_EXEC;
      end
      ST_EXEC: begin
        if (w_we && (w_ws == WS_SW)) begin
          w_next_state = ST_WAIT_SW;
        end else begin
          w_next_state = ST_WB;
        end
      end
      ST_WAIT_SW: begin
        if (sw_valid) begin
          w_sw_ack     = 1'b1;
          w_next_state = ST_WB;
        end
      end
      ST_WB: begin
        w_rf_we   = w_we && (w_ws != WS_ILLEGAL);
        w_pc_load = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
        w_next_state = ST_HALT;
`else
        w_next_state = ST_FETCH;
`endif
      end
      ST_HALT: begin
`ifdef SEQ_SINGLE_STEP_EN
        if (step_i) begin
          w_next_state = ST_FETCH;
        end
`else
        w_next_state = ST_FETCH;
`endif
      end
      default: begin
        w_next_state = ST_FETCH;
      end
    endcase
  end

  // IR capture on fetch ack, branch-compare capture in EXEC, retire count at WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr   <= '0;
      r_cmp_q   <= 1'b0;
      r_retired <= '0;
    end else begin
      if ((r_state == ST_FETCH) && imem_ack) begin
        r_instr <= imem_rdata;
      end
      if (r_state == ST_EXEC) begin
        r_cmp_q <= cmp_i;
      end
      if (w_pc_load) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  core_pc_unit #(
    .PC_RESET (PC_RESET)
  ) u_pc_unit (
    .clk    (clk),
    .rst    (rst),
    .load   (w_pc_load),
    .taken  (w_taken),
    .const8 (r_instr[IR_CONST_HI:IR_CONST_LO]),
    .pc     (w_pc)
  );

  // Strobes are forced low while reset is held so nothing escapes mid-abort.
  assign imem_req  = w_imem_req & ~rst;
  assign sw_ack    = w_sw_ack & ~rst;
  assign rf_we     = w_rf_we & ~rst;
  assign imem_addr = w_pc;
  assign pc        = w_pc;
  assign instr     = r_instr;
  assign wb_sel    = w_ws;
  assign retired   = r_retired;
  assign state_o   = r_state;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - self-checking bench: directed vector table, reset/wrap sequences, random instructions
module tb_core_sequencer;

  localparam logic [2:0] T_FETCH   = 3'd0;
  localparam logic [2:0] T_DECODE  = 3'd1;
  localparam logic [2:0] T_EXEC    = 3'd2;
  localparam logic [2:0] T_WAIT_SW = 3'd3;
  localparam logic [2:0] T_WB      = 3'd4;
  localparam logic [2:0] T_HALT    = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step_i = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        cmp_i = 1'b0;
  logic        sw_valid = 1'b0;
  logic        sw_ack;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic [31:0] pc;
  logic [31:0] retired;
  logic [2:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_pc  = 32'd0;
  logic [31:0] m_ret = 32'd0;

  always #5 clk = ~clk;

  core_sequencer dut (
    .clk        (clk),
    .rst        (rst),
`ifdef SEQ_SINGLE_STEP_EN
    .step_i     (step_i),
`endif
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .cmp_i      (cmp_i),
    .sw_valid   (sw_valid),
    .sw_ack     (sw_ack),
    .rf_we      (rf_we),
    .wb_sel     (wb_sel),
    .pc         (pc),
    .retired    (retired),
    .state_o    (state_o)
  );

  typedef struct {
    logic [31:0] ins;
    logic        c;
    int          ack_wait;
    int          sw_wait;
    logic [31:0] exp_pc;
    logic        exp_we;
  } vec_t;

  vec_t tab[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: architectural effect of one instruction from plain arithmetic.
  function automatic logic [31:0] model_next_pc(input logic [31:0] cur, input logic [31:0] ins, input logic c);
    int off;
    off = int'($signed(ins[7:0])) * 4;
    if (ins[31] || (ins[30] && c)) return cur + 32'(off);
    return cur + 32'd4;
  endfunction

  task automatic run_instr(input logic [31:0] ins, input logic c, input int ack_wait, input int sw_wait,
                           input bit use_tab, input logic [31:0] tab_pc, input logic tab_we);
    logic [31:0] exp_pc;
    logic [2:0]  st;
    bit   is_sw, exp_we, done, addr_checked, bad_we, bad_req;
    int   exp_cyc, cyc, req_cyc, sw_cyc, we_cnt, ack_cnt, ack_at, we_at;
    exp_pc  = model_next_pc(m_pc, ins, c);
    is_sw   = ins[29] && (ins[28:27] == 2'b01);
    exp_we  = ins[29] && (ins[28:27] != 2'b11);
    exp_cyc = 4 + ack_wait + (is_sw ? 1 + sw_wait : 0);
    done = 0; addr_checked = 0; bad_we = 0; bad_req = 0;
    cyc = 0; req_cyc = 0; sw_cyc = 0; we_cnt = 0; ack_cnt = 0; ack_at = -1; we_at = -1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      st         = state_o;
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      sw_valid   = 1'($urandom_range(0, 1));
      cmp_i      = ~c;
      step_i     = 1'($urandom_range(0, 1));
      case (st)
        T_FETCH: begin
          if (!addr_checked) begin
            check("imem_addr", imem_addr, m_pc);
            addr_checked = 1;
          end
          imem_ack   = (req_cyc == ack_wait);
          imem_rdata = imem_ack ? ins : $urandom;
          req_cyc++;
        end
        T_EXEC: cmp_i = c;
        T_WAIT_SW: begin
          sw_valid = (sw_cyc >= sw_wait);
          sw_cyc++;
        end
        T_WB: imem_ack = 1'b0;
        default: ;
      endcase
      #1;
      if (st == T_FETCH && imem_req !== 1'b1) bad_req = 1;
      if (st != T_FETCH && imem_req !== 1'b0) bad_req = 1;
      if (st == T_DECODE) check("instr_reg", instr, ins);
      if (sw_ack) begin ack_cnt++; ack_at = cyc; end
      if (rf_we) begin
        we_cnt++;
        we_at = cyc;
        if (st != T_WB) bad_we = 1;
      end
      if (st == T_WB) begin
        check("wb_sel", {30'd0, wb_sel}, {30'd0, ins[28:27]});
        done = 1;
      end
      cyc++;
    end
    if (!done) check("wb_reached_timeout", 32'd0, 32'd1);
    check("cycles", 32'(cyc), 32'(exp_cyc));
    check("imem_req_only_in_fetch", {31'd0, bad_req}, 32'd0);
    check("rf_we_only_in_wb", {31'd0, bad_we}, 32'd0);
    check("rf_we_count", 32'(we_cnt), {31'd0, exp_we});
    if (use_tab) check("rf_we_table", 32'(we_cnt), {31'd0, tab_we});
    check("sw_ack_count", 32'(ack_cnt), {31'd0, is_sw});
    if (is_sw && exp_we) check("rf_we_after_sw_ack", 32'(we_at), 32'(ack_at + 1));
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    step_i   = 1'b0;
    check("pc", pc, exp_pc);
    if (use_tab) check("pc_table", pc, tab_pc);
    check("retired", retired, m_ret + 32'd1);
    m_pc  = exp_pc;
    m_ret = m_ret + 32'd1;
`ifdef SEQ_SINGLE_STEP_EN
    check("state_after_wb", {29'd0, state_o}, {29'd0, T_HALT});
    repeat (3) begin
      @(negedge clk);
      step_i = 1'b0;
      imem_ack = 1'b1;
      #1;
      check("halt_holds", {29'd0, state_o}, {29'd0, T_HALT});
      check("halt_pc_stable", pc, m_pc);
    end
    @(negedge clk);
    step_i   = 1'b1;
    imem_ack = 1'b0;
    @(posedge clk);
    #1;
    step_i = 1'b0;
    check("step_to_fetch", {29'd0, state_o}, {29'd0, T_FETCH});
    check("step_no_retire", retired, m_ret);
`else
    check("state_after_wb", {29'd0, state_o}, {29'd0, T_FETCH});
`endif
  endtask

  initial begin
    tab[0]  = '{32'h2000_0507, 1'b0, 3, 0, 32'h04, 1'b1};
    tab[1]  = '{32'h0000_0000, 1'b0, 0, 0, 32'h08, 1'b0};
    tab[2]  = '{32'h3000_0000, 1'b1, 1, 0, 32'h0C, 1'b1};
    tab[3]  = '{32'h0000_0000, 1'b0, 2, 0, 32'h10, 1'b0};
    tab[4]  = '{32'h4000_00FE, 1'b1, 0, 0, 32'h08, 1'b0};
    tab[5]  = '{32'h8000_0002, 1'b0, 0, 0, 32'h10, 1'b0};
    tab[6]  = '{32'h4000_00FE, 1'b0, 0, 0, 32'h14, 1'b0};
    tab[7]  = '{32'h8000_0003, 1'b0, 0, 0, 32'h20, 1'b0};
    tab[8]  = '{32'h8000_0003, 1'b1, 1, 0, 32'h2C, 1'b0};
    tab[9]  = '{32'h2800_0300, 1'b0, 1, 5, 32'h30, 1'b1};
    tab[10] = '{32'h3800_0000, 1'b0, 0, 0, 32'h34, 1'b0};
    tab[11] = '{32'h0800_0000, 1'b0, 0, 0, 32'h38, 1'b0};
    tab[12] = '{32'h2800_0100, 1'b1, 0, 0, 32'h3C, 1'b1};
    tab[13] = '{32'hC000_00FF, 1'b0, 2, 0, 32'h38, 1'b0};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    imem_ack = 1'b1;
    #1;
    check("reset_imem_req", {31'd0, imem_req}, 32'd0);
    check("reset_rf_we", {31'd0, rf_we}, 32'd0);
    check("reset_sw_ack", {31'd0, sw_ack}, 32'd0);
    check("reset_state", {29'd0, state_o}, {29'd0, T_FETCH});
    check("reset_pc", pc, 32'd0);
    check("reset_instr", instr, 32'd0);
    check("reset_retired", retired, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    imem_ack = 1'b0;
    #1;
    check("post_reset_imem_req", {31'd0, imem_req}, 32'd1);

    for (int i = 0; i < 14; i++) begin
      run_instr(tab[i].ins, tab[i].c, tab[i].ack_wait, tab[i].sw_wait, 1'b1, tab[i].exp_pc, tab[i].exp_we);
    end

    // Reset landing in FETCH while an ack is offered.
    @(negedge clk);
    check("pre_abort_in_fetch", {31'd0, imem_req}, 32'd1);
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    check("abort_pc", pc, 32'd0);
    check("abort_state", {29'd0, state_o}, {29'd0, T_FETCH});
    check("abort_instr", instr, 32'd0);
    check("abort_retired", retired, 32'd0);
    check("abort_imem_req_low", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    imem_ack = 1'b0;
    #1;
    check("abort_imem_req_fresh", {31'd0, imem_req}, 32'd1);
    check("abort_stale_not_latched", instr, 32'd0);
    m_pc  = 32'd0;
    m_ret = 32'd0;

    // Backward jump from 0 then fall-through wrap back to 0.
    run_instr(32'h8000_00FF, 1'b0, 0, 0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    run_instr(32'h2000_0000, 1'b1, 1, 0, 1'b1, 32'h0000_0000, 1'b1);

    for (int i = 0; i < 40; i++) begin
      run_instr($urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'b0, 32'd0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
